secuencia_gen: RTL and testbench



---
 rtl/secuencia_gen.sv | 217 +++++++++++++++++++++
 tb/tb_secuencia_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/secuencia_gen.sv
// ---------------------------------------------------------------------------
// secuencia_gen
//
// Serial bit-sequence generator. On an accepted start it captures a pattern
// word and shifts it out MSB-first (bit len-1 first) on the serial line w,
// one bit per clock. The pattern can repeat, with GAP idle zero cycles
// between repetitions. Intended to feed the w input of a sequence detector.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   transfer request, only looked at while idle
//   pattern    in   WIDTH-bit word to send
//   len        in   bits per repetition (clamped to WIDTH, 0 = ignore start)
//   reps       in   repetitions (0 is treated as 1)
//   w          out  serial output (registered)
//   bit_valid  out  high while w carries a pattern bit
//   busy       out  high from the first bit through the last, gaps included
//   done       out  one-cycle pulse in the first idle cycle after the last bit
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// ---------------------------------------------------------------------------
module secuencia_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             w,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  // Counter widths; kept at least one bit wide so degenerate parameter
  // choices (WIDTH=1, GAP=0) still elaborate.
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;     // captured pattern
  logic [IDX_W-1:0] idx_q, idx_d;     // index of the bit currently on w
  logic [IDX_W-1:0] last_q, last_d;   // L-1, reload value for each repetition
  logic [GAP_W-1:0] gap_q, gap_d;     // gap cycles still to go after this one
  logic [REP_W-1:0] rep_q, rep_d;     // repetitions still to go after this one

  logic w_q, w_d;
  logic valid_q, valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // -------------------------------------------------------------------------
  // Input decode for the accepting edge
  // -------------------------------------------------------------------------
  logic             accept;
  logic [IDX_W-1:0] in_last;     // effective length minus one
  logic [REP_W-1:0] in_rep_rem;  // effective reps minus one

  assign accept = (state_q == S_IDLE) && start && (len != '0);

  always_comb begin
    in_last = '0;
    if (len > LEN_W'(WIDTH)) begin
      in_last = IDX_W'(WIDTH - 1);
    end else begin
      in_last = IDX_W'(len - LEN_W'(1));
    end
  end

  // reps == 0 behaves like reps == 1, i.e. nothing left after the first pass.
  assign in_rep_rem = (reps == '0) ? '0 : reps - REP_W'(1);

  // -------------------------------------------------------------------------
  // Status of the running counters
  // -------------------------------------------------------------------------
  logic             bit_last;
  logic             reps_left;
  logic             gap_last;
  logic [IDX_W-1:0] idx_dec;

  assign bit_last  = (idx_q == '0);
  assign reps_left = (rep_q != '0);
  assign gap_last  = (gap_q == '0);
  assign idx_dec   = idx_q - IDX_W'(1);

  // -------------------------------------------------------------------------
  // State register (with the datapath counters that travel with it)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      gap_q   <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      rep_q   <= rep_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    last_d  = last_q;
    gap_d   = gap_q;
    rep_d   = rep_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SEND;
          pat_d   = pattern;
          idx_d   = in_last;
          last_d  = in_last;
          rep_d   = in_rep_rem;
        end
      end

      S_SEND: begin
        if (!bit_last) begin
          idx_d = idx_dec;
        end else if (reps_left) begin
          // The repetition count is consumed when the next pass is
          // committed to, whether or not a gap sits in between.
          rep_d = rep_q - REP_W'(1);
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_W'(GAP - 1);
          end else begin
            idx_d = last_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_GAP: begin
        if (gap_last) begin
          state_d = S_SEND;
          idx_d   = last_q;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: computes the next value of each output flop from the
  // next state, so every output is valid in the same cycle as its state.
  // -------------------------------------------------------------------------
  always_comb begin
    w_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    if (state_d == S_SEND) begin
      // pat_d already holds the incoming pattern on the accepting edge,
      // so the first bit needs no special case.
      w_d     = pat_d[idx_d];
      valid_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
    // Only the natural end of a transfer pulses done; reset overrides this
    // in the output register below.
    done_d = (state_q == S_SEND) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      w_q     <= w_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign w         = w_q;
  assign bit_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_secuencia_gen.sv
// ---------------------------------------------------------------------------
// tb_secuencia_gen
//
// Scoreboard bench for secuencia_gen. The stimulus process issues transfers
// and, for each accepted one, expands the expected busy-cycle stream
// ({bit_valid, w} per cycle: L pattern bits MSB-first, then GAP zero cycles
// between repetitions) into a queue together with the expected busy length.
// A separate monitor samples on the falling edge and pops/compares.
// ---------------------------------------------------------------------------
module tb_secuencia_gen;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;
  localparam int REP_W = 4;
  localparam int GAP   = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] pattern = '0;
  logic [LEN_W-1:0] len = '0;
  logic [REP_W-1:0] reps = '0;
  logic             w, bit_valid, busy, done;

  always #5 clk = ~clk;

  secuencia_gen #(
    .WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .GAP(GAP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .len(len), .reps(reps), .w(w), .bit_valid(bit_valid),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];   // expected {bit_valid, w} per busy cycle
  int         tot_q[$];   // expected busy length per transfer

  logic rst_at_edge = 1'b1;
  always @(posedge clk) rst_at_edge <= reset;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expands one accepted request into its cycle stream.
  task automatic model_accept(input logic [WIDTH-1:0] p, input int l, input int r,
                              output int total);
    int eff_l, eff_r;
    eff_l = (l > WIDTH) ? WIDTH : l;
    eff_r = (r == 0) ? 1 : r;
    for (int k = 0; k < eff_r; k++) begin
      for (int b = eff_l - 1; b >= 0; b--) exp_q.push_back({1'b1, p[b]});
      if (k < eff_r - 1) repeat (GAP) exp_q.push_back(2'b00);
    end
    total = eff_r * eff_l + (eff_r - 1) * GAP;
    tot_q.push_back(total);
  endtask

  // Drives one start pulse from idle; returns with start low, one cycle
  // after the accepting edge (first bit on w).
  task automatic issue(input logic [WIDTH-1:0] p, input int l, input int r,
                       output int total);
    pattern = p;
    len     = LEN_W'(l);
    reps    = REP_W'(r);
    start   = 1'b1;
    total   = 0;
    if (l != 0) model_accept(p, l, r, total);
    $display("txn pattern=%02h len=%0d reps=%0d busy_cycles=%0d", p, l, r, total);
    tick();
    start = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  initial begin
    int         run;
    logic       prev_busy;
    logic [1:0] e;
    run = 0;
    prev_busy = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        check("reset_outputs", {28'd0, w, bit_valid, busy, done}, 32'd0);
        run = 0;
        prev_busy = 1'b0;
      end else begin
        if (busy) begin
          run++;
          check("done_while_busy", {31'd0, done}, 32'd0);
          check("busy_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("stream", {30'd0, bit_valid, w}, {30'd0, e});
          end
        end else begin
          check("idle_outputs", {30'd0, w, bit_valid}, 32'd0);
          if (prev_busy) check("done_after_busy", {31'd0, done}, 32'd1);
          if (done) begin
            check("done_expected", {31'd0, tot_q.size() != 0}, 32'd1);
            if (tot_q.size() != 0) check("busy_len", run, tot_q.pop_front());
            run = 0;
          end
        end
        prev_busy = busy;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int tot, tot2, mode;
    logic [WIDTH-1:0] p;
    int l, r;

    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Single repetition: 1,1,0,1
    issue(8'h0D, 4, 1, tot);
    repeat (tot) tick();
    tick();

    // Repeats with gaps: 101 00 101 00 101
    issue(8'h05, 3, 3, tot);
    repeat (tot) tick();
    tick();

    // len = 0 is ignored
    issue(8'hFF, 0, 2, tot);
    repeat (3) tick();

    // len clamped to WIDTH
    issue(8'hA5, 12, 1, tot);
    repeat (tot) tick();
    tick();

    // reps = 0 behaves like one repetition
    issue(8'h9C, 5, 0, tot);
    repeat (tot) tick();
    tick();

    // start during busy with different inputs is ignored
    issue(8'h05, 3, 3, tot);
    repeat (3) tick();
    pattern = 8'hFF; len = 4'd8; reps = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (tot - 4) tick();
    tick();

    // start held through the done cycle gives a back-to-back transfer
    pattern = 8'hB2; len = 4'd6; reps = 4'd2; start = 1'b1;
    model_accept(8'hB2, 6, 2, tot);
    $display("txn pattern=b2 len=6 reps=2 busy_cycles=%0d (start held)", tot);
    tick();
    pattern = 8'h3C; len = 4'd4; reps = 4'd1;
    repeat (tot) tick();
    model_accept(8'h3C, 4, 1, tot2);
    $display("txn pattern=3c len=4 reps=1 busy_cycles=%0d (back-to-back)", tot2);
    tick();
    start = 1'b0;
    repeat (tot2) tick();
    tick();

    // Reset on the third bit of the gapped transfer; no done must follow
    issue(8'h05, 3, 3, tot);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    exp_q.delete();
    tot_q.delete();
    $display("txn reset asserted mid-transfer");
    reset = 1'b0;
    repeat (3) tick();

    // Normal transfer after reset
    issue(8'h0D, 4, 2, tot);
    repeat (tot) tick();
    tick();

    // Randomized transfers
    for (int n = 0; n < 40; n++) begin
      p = WIDTH'($urandom);
      l = $urandom_range(0, 12);
      r = $urandom_range(0, 4);
      mode = $urandom_range(0, 3);
      issue(p, l, r, tot);
      if (tot == 0) begin
        repeat (2) tick();
        continue;
      end
      for (int c = 0; c < tot; c++) begin
        pattern = WIDTH'($urandom);
        len     = LEN_W'($urandom_range(0, 12));
        reps    = REP_W'($urandom_range(0, 4));
        start   = (mode == 0) && (c == tot / 2);
        tick();
      end
      start = 1'b0;
      // Now in the done cycle; zero extra cycles makes the next start
      // land in it.
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (5) tick();
    check("queue_drained", exp_q.size(), 0);
    check("done_drained", tot_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
